// File: rtl/branch_target_buffer_pkg.sv
// Shared encodings for the branch target buffer: EX branch types and the
// 2-bit saturating direction counter states.
package branch_target_buffer_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } branch_type_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Sequential fall-through PC, 32-bit modulo.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and
// resolved outcome. Holds at ST on taken and at SNT on not-taken.
module btb_sat_counter
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward the resolved direction, clamping at the ends.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational IF-stage lookup; EX-stage resolution updates the table and
// raises MispredE / RedirectPCE for the hazard unit.
// Optional feature macro: BTB_STATS_EN (branch and misprediction counters).
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic [2:0]  BranchTypeE,
    input  logic        BrValidE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredE,
    output logic [31:0] RedirectPCE,
    output logic [31:0] BrCountE,
    output logic [31:0] MispredCntE
);

    localparam int TAG_W   = 30 - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic             is_br_e, upd_e;
    logic [1:0]       ctr_upd_e;

    // Word-offset bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[31:IDX_W+2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[31:IDX_W+2];

    assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign is_br_e = (BranchTypeE != NOBRANCH);
    assign upd_e   = BrValidE && is_br_e;

    btb_sat_counter u_sat_counter (
        .ctr      (ctr_q[idx_e]),
        .taken    (BranchE),
        .ctr_next (ctr_upd_e)
    );

    // IF lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        PredTakenF  = hit_f && ctr_q[idx_f][1];
        PredTargetF = PredTakenF ? target_q[idx_f] : pc_plus4(PCF);
    end

    // Misprediction detection and the corrected next PC for the EX instruction.
    always_comb begin
        MispredE    = 1'b0;
        RedirectPCE = (is_br_e && BranchE) ? BrTargetE : pc_plus4(PCE);
        if (BrValidE) begin
            if (is_br_e) begin
                MispredE = (BranchE != PredTakenE) ||
                           (BranchE && (PredTargetE != BrTargetE));
            end else begin
                MispredE = PredTakenE;
            end
        end
    end

    // Table write port: train on hits, allocate only on taken misses.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_e) begin
            if (hit_e) begin
                ctr_d[idx_e] = ctr_upd_e;
                if (BranchE) target_d[idx_e] = BrTargetE;
            end else if (BranchE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = BrTargetE;
                ctr_d[idx_e]    = WT;
            end
        end
    end

    // Valid bits and counters are reset; reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target payload; meaningless while the entry is invalid, so no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BTB_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Resolved-branch and misprediction counters, wrapping modulo 2**32.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (upd_e) br_cnt_d = br_cnt_q + 32'd1;
        if (BrValidE && MispredE) mis_cnt_d = mis_cnt_q + 32'd1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign BrCountE    = br_cnt_q;
    assign MispredCntE = mis_cnt_q;
`else
    assign BrCountE    = 32'd0;
    assign MispredCntE = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed testbench for branch_target_buffer (IDX_W=6).
// Statistics expectations follow the BTB_STATS_EN macro.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [2:0]  BranchTypeE;
    logic        BrValidE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredE;
    logic [31:0] RedirectPCE;
    logic [31:0] BrCountE;
    logic [31:0] MispredCntE;

    int total = 0;
    int bad   = 0;

    branch_target_buffer #(.IDX_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .BranchTypeE (BranchTypeE),
        .BrValidE    (BrValidE),
        .PCE         (PCE),
        .BranchE     (BranchE),
        .BrTargetE   (BrTargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredE    (MispredE),
        .RedirectPCE (RedirectPCE),
        .BrCountE    (BrCountE),
        .MispredCntE (MispredCntE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an EX-stage resolution and let combinational outputs settle.
    task automatic ex(input logic v, input logic [2:0] bt, input logic [31:0] pce,
                      input logic br, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt);
        BrValidE    = v;
        BranchTypeE = bt;
        PCE         = pce;
        BranchE     = br;
        BrTargetE   = tgt;
        PredTakenE  = pt;
        PredTargetE = ptgt;
        #1;
    endtask

    task automatic idle();
        BrValidE = 1'b0;
        BranchTypeE = NOBRANCH;
        PredTakenE = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_tgt);
        PCF = pc;
        #1;
        chk({tag, "_taken"},  {31'd0, PredTakenF}, {31'd0, exp_t});
        chk({tag, "_target"}, PredTargetF, exp_tgt);
    endtask

    task automatic chk_stats(input string tag, input int br, input int mis);
`ifdef BTB_STATS_EN
        chk({tag, "_brcnt"},  BrCountE, 32'(br));
        chk({tag, "_miscnt"}, MispredCntE, 32'(mis));
`else
        chk({tag, "_brcnt"},  BrCountE, 32'd0);
        chk({tag, "_miscnt"}, MispredCntE, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        PCF = 32'h100;
        BrValidE = 1'b0; BranchTypeE = NOBRANCH; PCE = 32'h0; BranchE = 1'b0;
        BrTargetE = 32'h0; PredTakenE = 1'b0; PredTargetE = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        chk("rst_mispred", {31'd0, MispredE}, 32'd0);
        chk_stats("rst", 0, 0);

        // S1: taken BEQ, allocate; lookup same cycle sees old entry
        PCF = 32'h100;
        ex(1, BEQ, 32'h100, 1, 32'h80, 0, 32'h104);
        chk("s1_mispred", {31'd0, MispredE}, 32'd1);
        chk("s1_redirect", RedirectPCE, 32'h80);
        chk("s1_nobypass", {31'd0, PredTakenF}, 32'd0);
        tick(); idle();
        look("s1", 32'h100, 1'b1, 32'h80);

        // S2: not taken, predicted taken: ctr 10 -> 01
        ex(1, BEQ, 32'h100, 0, 32'h80, 1, 32'h80);
        chk("s2_mispred", {31'd0, MispredE}, 32'd1);
        chk("s2_redirect", RedirectPCE, 32'h104);
        tick(); idle();
        look("s2", 32'h100, 1'b0, 32'h104);

        // S3: not taken, predicted not taken: ctr 01 -> 00
        ex(1, BEQ, 32'h100, 0, 32'h80, 0, 32'h104);
        chk("s3_mispred", {31'd0, MispredE}, 32'd0);
        tick(); idle();
        look("s3", 32'h100, 1'b0, 32'h104);

        // S4: taken once: ctr 00 -> 01, still not taken
        ex(1, BEQ, 32'h100, 1, 32'h80, 0, 32'h104);
        chk("s4_mispred", {31'd0, MispredE}, 32'd1);
        tick(); idle();
        look("s4", 32'h100, 1'b0, 32'h104);

        // S5: taken again: ctr 01 -> 10
        ex(1, BEQ, 32'h100, 1, 32'h80, 0, 32'h104);
        tick(); idle();
        look("s5", 32'h100, 1'b1, 32'h80);

        // S6: correctly predicted taken: ctr 10 -> 11
        ex(1, BEQ, 32'h100, 1, 32'h80, 1, 32'h80);
        chk("s6_mispred", {31'd0, MispredE}, 32'd0);
        tick(); idle();

        // S7: taken to a new target: saturates at 11, target replaced
        ex(1, BEQ, 32'h100, 1, 32'h90, 1, 32'h80);
        chk("s7_mispred", {31'd0, MispredE}, 32'd1);
        chk("s7_redirect", RedirectPCE, 32'h90);
        tick(); idle();
        look("s7", 32'h100, 1'b1, 32'h90);

        // S8: one not-taken from saturated 11 -> 10, still taken
        ex(1, BEQ, 32'h100, 0, 32'h90, 1, 32'h90);
        tick(); idle();
        look("s8", 32'h100, 1'b1, 32'h90);

        // S9: alias at same index, different tag
        ex(1, BNE, 32'h200, 1, 32'h300, 0, 32'h204);
        chk("s9_mispred", {31'd0, MispredE}, 32'd1);
        tick(); idle();
        look("s9_old", 32'h100, 1'b0, 32'h104);
        look("s9_new", 32'h200, 1'b1, 32'h300);

        // S10: not-taken miss at the same index does not write
        ex(1, BLT, 32'h500, 0, 32'h0, 0, 32'h504);
        chk("s10_mispred", {31'd0, MispredE}, 32'd0);
        tick(); idle();
        look("s10", 32'h200, 1'b1, 32'h300);

        // S11: non-branch predicted taken
        ex(1, NOBRANCH, 32'h40, 0, 32'h0, 1, 32'h999);
        chk("s11_mispred", {31'd0, MispredE}, 32'd1);
        chk("s11_redirect", RedirectPCE, 32'h44);
        tick(); idle();
        look("s11", 32'h40, 1'b0, 32'h44);

        // S12: invalid EX slot with mismatch
        ex(0, BEQ, 32'h100, 1, 32'h80, 0, 32'h104);
        chk("s12_mispred", {31'd0, MispredE}, 32'd0);
        tick(); idle();

        // S13: PC wrap on non-branch redirect
        ex(1, NOBRANCH, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0);
        chk("s13_mispred", {31'd0, MispredE}, 32'd1);
        chk("s13_redirect", RedirectPCE, 32'h0);
        tick(); idle();
        chk_stats("s13", 10, 9);

        // S14: reset mid-stream with a concurrent update
        rst = 1'b1;
        ex(1, BEQ, 32'h600, 1, 32'h700, 0, 32'h604);
        tick(); idle();
        rst = 1'b0;
        #1;
        look("s14_a", 32'h200, 1'b0, 32'h204);
        look("s14_b", 32'h600, 1'b0, 32'h604);
        chk_stats("s14", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
